ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte to the keyboard (e.g. 0xED LED set, 0xFF reset).
//  Opposite direction to the keyboard receiver; shares ps2_clk/ps2_data via open-drain pull-downs.
//  Runs on clk100 beside the keyboard receiver. busy tells the receiver to ignore the lines during a send.
// PARAMETERS
//  INHIBIT_CYCLES  12000   clk cycles ps2_clk is held low before the start bit (120 us @100 MHz, >=100 us)
//  TIMEOUT_CYCLES  200000  per-edge watchdog: max clk cycles between expected device events (2 ms)
//  FILTER_LEN      4       consecutive equal samples needed to accept a new ps2_clk level (glitch filter)
// PORTS
//  clk          in   1  100 MHz system clock
//  reset        in   1  asynchronous, active-low reset
//  tx_data      in   8  command byte to send
//  tx_valid     in   1  request; accepted when tx_valid & tx_ready on a rising clk edge
//  tx_ready     out  1  high only in IDLE
//  busy         out  1  high from acceptance until done
//  done         out  1  one-cycle pulse at end of transfer (success or failure)
//  ack_err      out  1  valid with done: 1 = no ack or timeout, 0 = device acknowledged
//  ps2_clk_in   in   1  pad level of PS/2 clock (asynchronous)
//  ps2_data_in  in   1  pad level of PS/2 data (asynchronous)
//  ps2_clk_oe   out  1  1 = drive ps2_clk low, 0 = release (pull-up)
//  ps2_data_oe  out  1  1 = drive ps2_data low, 0 = release
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE; tx_ready=1; busy=0; done=0; ack_err=0; both _oe=0 immediately.
//  Inputs: ps2_clk_in, ps2_data_in pass through a 2-FF synchroniser. ps2_clk is then filtered (FILTER_LEN).
//   fall = one-cycle pulse on a filtered 1->0 transition.
//  Accept: latch tx_data, frame = {stop=1, parity=~^tx_data (odd), tx_data}; bit_cnt=0; tx_ready=0, busy=1.
//  FSM:
//   IDLE    : _oe=0; on accept -> INHIBIT.
//   INHIBIT : clk_oe=1 for INHIBIT_CYCLES; last cycle sets data_oe=1 (start bit) -> RELEASE.
//   RELEASE : clk_oe=0, data_oe=1; watchdog cleared -> SHIFT.
//   SHIFT   : on each fall, data_oe = ~frame[bit_cnt]; bit_cnt++ (bits 0-7 data LSB first, 8 parity, 9 stop).
//             The fall that drives the stop bit (data released) -> ACK.
//   ACK     : on next fall sample ps2_data (synced): 0 -> ok -> WAITIDLE; 1 -> ack_err=1 -> FINISH.
//   WAITIDLE: wait until synced ps2_clk=1 and ps2_data=1 -> FINISH.
//   FINISH  : one cycle: done=1 (ack_err as set); both _oe=0 -> IDLE (tx_ready=1 next cycle).
//  Watchdog: counter reset on entering RELEASE and on every fall. Reaching TIMEOUT_CYCLES in
//   SHIFT/ACK/WAITIDLE releases both lines, sets ack_err=1 -> FINISH.
//  Latency: tx_ready returns 1 exactly one cycle after the done pulse. tx_valid while busy is ignored, not queued.
//  tx_data is sampled only at accept; later changes have no effect on the frame in flight.
//  Timing: data_oe changes in the cycle after the synced fall is seen (device samples on rising edge ~30 us later).
//  Simultaneous: an accept and FINISH never overlap (tx_ready=0 in FINISH).
//  Counter widths: $clog2 of each parameter+1; bit_cnt 4 bits, never exceeds 10.
//  Reset mid-transfer: lines released at once, frame discarded, no done pulse.
// TESTING  (sim: INHIBIT_CYCLES=50, TIMEOUT_CYCLES=2000, device model clock period 400 cycles)
//  Send 0xED, model acks -> clk low >=50 cyc, then bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
//   done=1, ack_err=0, tx_ready=1 next cycle.
//  Send 0x01 and 0xFF back to back -> parity bits 0 and 1; second byte accepted only after first done.
//  Model leaves data high on 11th clock -> done=1, ack_err=1, both _oe=0.
//  Model never clocks after inhibit -> done+ack_err exactly TIMEOUT_CYCLES after RELEASE; lines released.
//  reset=0 during bit 4 of 0xA5 -> _oe=0 same cycle, busy=0, no done; next send of 0x55 is correct.
//  Glitch of 2 cycles low on ps2_clk_in during SHIFT -> no fall, bit_cnt unchanged.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// Sends one command byte to a PS/2 device over the shared open-drain clock/data pair.
// The host holds the clock low to request the bus, drives the start bit, and then
// follows the device-generated clock: it shifts out eight data bits (LSB first),
// an odd parity bit and a stop bit, and finally checks for the device's ack bit.
// A per-event watchdog makes sure a silent or stuck device cannot hang the sender.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W  = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FILT_W = $clog2(FILTER_LEN + 1);

    localparam logic [INH_W-1:0]  INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_ONE    = WD_W'(1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RELEASE,
        S_SHIFT,
        S_ACK,
        S_WAITIDLE,
        S_FINISH
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        clk_sync_q;
    logic [1:0]        data_sync_q;
    logic              clk_s;
    logic              data_s;
    logic              filt_q;
    logic [FILT_W-1:0] filt_cnt_q;
    logic              fall_q;

    logic [INH_W-1:0]  inh_q, inh_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [9:0]        frame_q, frame_d;
    logic              data_oe_q, data_oe_d;
    logic              ack_err_q, ack_err_d;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // Bring both pad levels into the clk domain; idle bus level is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
        end
    end

    // Accept a new clock level only after FILTER_LEN equal samples; flag the 1->0 change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else if (clk_s == filt_q) begin
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else if (filt_cnt_q == FILT_LAST) begin
            filt_q     <= clk_s;
            filt_cnt_q <= '0;
            fall_q     <= filt_q;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
            fall_q     <= 1'b0;
        end
    end

    // Transfer state and datapath registers; reset drops both line drivers at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            inh_q     <= '0;
            wd_q      <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            data_oe_q <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_q     <= inh_d;
            wd_q      <= wd_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            data_oe_q <= data_oe_d;
            ack_err_q <= ack_err_d;
        end
    end

    // Next-state logic: inhibit, start bit, follow device clock falls, then check the ack.
    always_comb begin
        state_d   = state_q;
        inh_d     = inh_q;
        wd_d      = wd_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        data_oe_d = data_oe_q;
        ack_err_d = ack_err_q;

        case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    frame_d   = {1'b1, ~^tx_data, tx_data};
                    bit_cnt_d = '0;
                    inh_d     = '0;
                    ack_err_d = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (inh_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    state_d   = S_RELEASE;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end

            S_RELEASE: begin
                data_oe_d = 1'b1;
                wd_d      = WD_ONE;
                state_d   = S_SHIFT;
            end

            S_SHIFT: begin
                if (fall_q) begin
                    data_oe_d = ~frame_q[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    wd_d      = WD_ONE;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end else if (wd_q == WD_LAST) begin
                    data_oe_d = 1'b0;
                    ack_err_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end

            S_ACK: begin
                if (fall_q) begin
                    wd_d = WD_ONE;
                    if (!data_s) begin
                        state_d = S_WAITIDLE;
                    end else begin
                        ack_err_d = 1'b1;
                        state_d   = S_FINISH;
                    end
                end else if (wd_q == WD_LAST) begin
                    data_oe_d = 1'b0;
                    ack_err_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end

            S_WAITIDLE: begin
                if (clk_s && data_s) begin
                    state_d = S_FINISH;
                end else if (wd_q == WD_LAST) begin
                    data_oe_d = 1'b0;
                    ack_err_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end

            S_FINISH: begin
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end

            default: begin
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FINISH);
    assign ack_err     = ack_err_q;
    assign ps2_clk_oe  = (state_q == S_INHIBIT);
    assign ps2_data_oe = data_oe_q;

endmodule
